// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package imem_loader_pkg;

   localparam int LEN_W  = 16;
   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;

   // States in which the loader consumes stream bytes.
   function automatic logic accepts_bytes(input state_t s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
   endfunction

   // States from which a new load may be started.
   function automatic logic can_start(input state_t s);
      return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four stream bytes (MSB first) into one 32-bit word.
// word/word_ready are combinational so the owner can register the
// completed word on the same edge that accepts its fourth byte.
module imem_loader_word_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_byte,
   output logic [WORD_W-1:0] word,
   output logic              word_ready
);

   logic [WORD_W-BYTE_W-1:0] shreg;
   logic [1:0]               cnt;

   // Shift accepted bytes in and count position within the current word.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         shreg <= '0;
         cnt   <= 2'd0;
      end else if (in_valid) begin
         shreg <= {shreg[WORD_W-2*BYTE_W-1:0], in_byte};
         cnt   <= cnt + 2'd1;
      end
   end

   // The fourth byte completes the word together with the three held bytes.
   always_comb begin
      word       = {shreg, in_byte};
      word_ready = in_valid && (cnt == 2'd3);
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream (length, payload words,
// XOR checksum), writes words to instruction memory and releases the core
// only after the checksum matches.
//
// Handshake: a byte moves on every posedge where byte_valid && byte_ready;
// byte_ready is registered from the next state, the source must hold
// byte_data while byte_valid is high and byte_ready is low.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   state_t              state;
   state_t              next_state;
   logic [BYTE_W-1:0]   len_hi;
   logic [LEN_W-1:0]    len;
   logic [LEN_W-1:0]    len_full;
   logic [LEN_W-1:0]    word_cnt;
   logic [BYTE_W-1:0]   chk;
   logic                xfer;
   logic                data_xfer;
   logic                begin_load;
   logic                last_word;
   logic [WORD_W-1:0]   asm_word;
   logic                asm_ready;

   assign xfer       = byte_valid && byte_ready;
   assign data_xfer  = xfer && (state == ST_DATA);
   assign begin_load = start && can_start(state);
   assign len_full   = {len_hi, byte_data};
   assign last_word  = (word_cnt == (len - 16'd1));

   imem_loader_word_assembler u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (begin_load),
      .in_valid   (data_xfer),
      .in_byte    (byte_data),
      .word       (asm_word),
      .word_ready (asm_ready)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state decode; start is only honoured outside an active load.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (start) next_state = ST_LEN_HI;
         ST_LEN_HI: if (xfer)  next_state = ST_LEN_LO;
         ST_LEN_LO: begin
            if (xfer) begin
               if (len_full > DEPTH_L)    next_state = ST_ERR;
               else if (len_full == '0)   next_state = ST_CHECK;
               else                       next_state = ST_DATA;
            end
         end
         ST_DATA:   if (data_xfer && asm_ready && last_word) next_state = ST_CHECK;
         ST_CHECK:  if (xfer) next_state = (byte_data == chk) ? ST_DONE : ST_ERR;
         ST_DONE:   if (start) next_state = ST_LEN_HI;
         ST_ERR:    if (start) next_state = ST_LEN_HI;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Length capture, checksum, word counter and the one-cycle write strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_hi     <= '0;
         len        <= '0;
         word_cnt   <= '0;
         chk        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (begin_load) begin
            word_cnt <= '0;
            chk      <= '0;
         end
         if (xfer && (state == ST_LEN_HI)) len_hi <= byte_data;
         if (xfer && (state == ST_LEN_LO)) len    <= len_full;
         if (data_xfer) chk <= chk ^ byte_data;
         if (data_xfer && asm_ready) begin
            imem_we    <= 1'b1;
            imem_wdata <= asm_word;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            word_cnt   <= word_cnt + 16'd1;
         end
      end
   end

   // Status outputs are registered decodes of the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_ready <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         cpu_hold   <= 1'b1;
      end else begin
         byte_ready <= accepts_bytes(next_state);
         done       <= (next_state == ST_DONE);
         error      <= (next_state == ST_ERR);
         cpu_hold   <= (next_state != ST_DONE);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: framed loads with a write scoreboard.
module tb_imem_loader;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   int n_writes = 0;
   logic [ADDR_W+31:0] exp_q[$];
   int xfer_q[$];
   int we_q[$];
   logic [31:0] word_buf [0:DEPTH];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Write monitor: every strobe must match the next expected (addr, data).
   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         n_writes++;
         we_q.push_back(cyc);
         check("we_in_done_or_err", {62'd0, done, error}, 64'd0);
         if (exp_q.size() == 0) check("unexpected_write", {27'd0, imem_addr, imem_wdata}, 64'd0);
         else check("imem_write", {27'd0, imem_addr, imem_wdata}, {27'd0, exp_q.pop_front()});
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Present one byte and hold it until accepted (bounded).
   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int n = 0;
      if (gap_max > 0) begin
         byte_valid = 1'b0;
         repeat ($urandom_range(0, gap_max)) tick();
      end
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 40) begin
         tick();
         n++;
      end
      if (!byte_ready) begin
         check("ready_timeout", 64'd0, 64'd1);
         byte_valid = 1'b0;
      end else begin
         tick();
         xfer_q.push_back(cyc);
      end
   endtask

   // Full frame from word_buf[0..n-1]; checksum is the payload XOR, flipped by chk_xor.
   // poke > 0 pulses start (valid low) after that many payload bytes.
   task automatic load_frame(input int n, input logic [7:0] chk_xor, input int gap_max, input int poke);
      logic [15:0] ln;
      logic [7:0]  chk;
      logic [7:0]  bt;
      logic [31:0] w;
      ln  = 16'(n);
      chk = 8'd0;
      pulse_start();
      send_byte(ln[15:8], gap_max);
      send_byte(ln[7:0], gap_max);
      if (n <= DEPTH) begin
         for (int wi = 0; wi < n; wi++) begin
            w = word_buf[wi];
            for (int b = 0; b < 4; b++) begin
               bt  = w[31-8*b -: 8];
               chk = chk ^ bt;
               if (b == 3) exp_q.push_back({ADDR_W'(wi), w});
               send_byte(bt, gap_max);
               if (poke == wi*4 + b + 1) begin
                  byte_valid = 1'b0;
                  pulse_start();
               end
            end
         end
         send_byte(chk ^ chk_xor, gap_max);
      end
      byte_valid = 1'b0;
      tick();
   endtask

   task automatic check_status(input string tag, input logic d, input logic e, input logic h);
      check({tag, "_done"},  {63'd0, done},     {63'd0, d});
      check({tag, "_error"}, {63'd0, error},    {63'd0, e});
      check({tag, "_hold"},  {63'd0, cpu_hold}, {63'd0, h});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w0;
      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) tick();
      check("rst_ready", {63'd0, byte_ready}, 64'd0);
      check("rst_we",    {63'd0, imem_we},    64'd0);
      check("rst_addr",  {59'd0, imem_addr},  64'd0);
      check("rst_wdata", {32'd0, imem_wdata}, 64'd0);
      check_status("rst", 1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      tick();
      check("idle_ready", {63'd0, byte_ready}, 64'd0);

      // 1: two-word image, good checksum, random gaps.
      word_buf[0] = 32'h20080005;
      word_buf[1] = 32'h2009000A;
      w0 = n_writes;
      load_frame(2, 8'h00, 2, 0);
      check_status("t1", 1'b1, 1'b0, 1'b0);
      check("t1_writes", 64'(n_writes - w0), 64'd2);
      check("t1_ready", {63'd0, byte_ready}, 64'd0);

      // 2: same image, checksum off by one bit.
      w0 = n_writes;
      load_frame(2, 8'h01, 1, 0);
      check_status("t2", 1'b0, 1'b1, 1'b1);
      check("t2_writes", 64'(n_writes - w0), 64'd2);

      // 3a: length DEPTH+1 rejected after the header.
      w0 = n_writes;
      load_frame(DEPTH + 1, 8'h00, 0, 0);
      repeat (3) tick();
      check_status("t3a", 1'b0, 1'b1, 1'b1);
      check("t3a_ready", {63'd0, byte_ready}, 64'd0);
      check("t3a_writes", 64'(n_writes - w0), 64'd0);

      // 3b: full depth image, addresses 0..DEPTH-1.
      for (int i = 0; i < DEPTH; i++) word_buf[i] = $urandom;
      w0 = n_writes;
      load_frame(DEPTH, 8'h00, 1, 0);
      check_status("t3b", 1'b1, 1'b0, 1'b0);
      check("t3b_writes", 64'(n_writes - w0), 64'(DEPTH));

      // 4: empty image, then empty image with bad checksum.
      w0 = n_writes;
      load_frame(0, 8'h00, 0, 0);
      check_status("t4a", 1'b1, 1'b0, 1'b0);
      load_frame(0, 8'h01, 0, 0);
      check_status("t4b", 1'b0, 1'b1, 1'b1);
      check("t4_writes", 64'(n_writes - w0), 64'd0);

      // 5: back-to-back stream, no stall, strobes right after bytes 6 and 10.
      word_buf[0] = $urandom;
      word_buf[1] = $urandom;
      xfer_q.delete();
      we_q.delete();
      load_frame(2, 8'h00, 0, 0);
      check_status("t5", 1'b1, 1'b0, 1'b0);
      check("t5_nbytes", 64'(xfer_q.size()), 64'd11);
      check("t5_we_count", 64'(we_q.size()), 64'd2);
      if (xfer_q.size() == 11 && we_q.size() == 2) begin
         check("t5_no_stall", 64'(xfer_q[10] - xfer_q[0]), 64'd10);
         check("t5_we_after_b6",  64'(we_q[0]), 64'(xfer_q[5]));
         check("t5_we_after_b10", 64'(we_q[1]), 64'(xfer_q[9]));
      end

      // 6a: reset after 5 payload bytes abandons the load.
      word_buf[0] = 32'hA1B2C3D4;
      word_buf[1] = 32'h55667788;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      exp_q.push_back({ADDR_W'(0), word_buf[0]});
      for (int b = 0; b < 4; b++) send_byte(word_buf[0][31-8*b -: 8], 0);
      send_byte(word_buf[1][31:24], 0);
      byte_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t6_ready", {63'd0, byte_ready}, 64'd0);
      check("t6_we",    {63'd0, imem_we},    64'd0);
      check("t6_addr",  {59'd0, imem_addr},  64'd0);
      check_status("t6", 1'b0, 1'b0, 1'b1);
      tick();

      // 6b: fresh load from address 0 after the reset.
      word_buf[0] = $urandom;
      word_buf[1] = $urandom;
      load_frame(2, 8'h00, 1, 0);
      check_status("t6b", 1'b1, 1'b0, 1'b0);

      // 6c: start pulsed mid-payload is ignored.
      for (int i = 0; i < 3; i++) word_buf[i] = $urandom;
      w0 = n_writes;
      load_frame(3, 8'h00, 0, 5);
      check_status("t6c", 1'b1, 1'b0, 1'b0);
      check("t6c_writes", 64'(n_writes - w0), 64'd3);

      tick();
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
